// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Data-RAM controller that sits between the core's RAM port and an internal
//   byte array. It serves LD/ST/PUSH/POP traffic. The core gives a one-cycle
//   read or write strobe. The controller waits a fixed number of cycles and
//   then pulses o_done. Read data stays on o_rdata until the next read
//   completes, so the core's write-back stage can sample it late. Address bits
//   above ADDR_W are dropped, so stack addresses near 0xFFFF alias onto the top
//   of the array.
//
//   Optional feature: define DMEM_MMIO_EN to map a small GPIO window at
//   0xFF00..0xFF0F that bypasses the array:
//     0xFF00 write -> o_gpio, 0xFF00 read -> o_gpio
//     0xFF01 read  -> i_gpio
//     other window addresses read 0, writes are discarded
//   With the macro undefined, every address goes to the array and o_gpio is 0.
//
// Parameters
//   ADDR_W       array index width, depth = 2**ADDR_W bytes
//   WAIT_CYCLES  extra wait cycles before completion (0..15)
//
// Ports
//   i_clk    clock
//   i_rst    asynchronous active-high reset
//   i_addr   byte address, sampled with the strobe
//   i_wdata  write data, sampled with the strobe
//   i_read   read strobe (one-cycle pulse)
//   i_write  write strobe (one-cycle pulse)
//   o_rdata  read data, updated only when a read completes
//   o_done   one-cycle completion pulse
//   o_busy   high while a request is in flight (including the done cycle)
//   o_err    sticky protocol-error flag, cleared only by reset
//   i_gpio   MMIO input (DMEM_MMIO_EN only)
//   o_gpio   MMIO output register (DMEM_MMIO_EN only)
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  input  logic        i_read,
  input  logic        i_write,
  output logic [7:0]  o_rdata,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_err,
  input  logic [7:0]  i_gpio,
  output logic [7:0]  o_gpio
);

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        rd_q;
  logic        wr_q;

  logic [7:0]  mem [0:DEPTH-1];

  logic              strobe;
  logic              fire;
  logic [15:0]       acc_addr;
  logic [7:0]        acc_wdata;
  logic              acc_rd;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_idx;
  logic              in_window;
  logic              mem_we;
  logic              rd_en;
  logic [7:0]        rdata_next;

  assign strobe = i_read | i_write;

  // The access happens on the edge that enters ACCESS. Then o_done and
  // o_rdata become visible together in the ACCESS cycle. With zero wait
  // cycles that edge is the strobe edge itself, so the live inputs are used
  // in place of the latched request.
  assign fire      = ((state == IDLE) && strobe && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (cnt == 4'd1));
  assign acc_addr  = (state == IDLE) ? i_addr  : addr_q;
  assign acc_wdata = (state == IDLE) ? i_wdata : wdata_q;
  assign acc_rd    = (state == IDLE) ? i_read  : rd_q;
  assign acc_wr    = (state == IDLE) ? i_write : wr_q;
  assign acc_idx   = acc_addr[ADDR_W-1:0];

  // A request with both read and write set is a protocol error. It makes no
  // array access and leaves o_rdata alone.
  assign mem_we = fire & acc_wr & ~acc_rd & ~in_window & ~i_rst;
  assign rd_en  = fire & acc_rd & ~acc_wr;

`ifdef DMEM_MMIO_EN
  logic [7:0] gpio_q;

  assign in_window = (acc_addr[15:4] == 12'hFF0);
  assign o_gpio    = gpio_q;

  always_comb begin
    rdata_next = mem[acc_idx];
    if (in_window) begin
      rdata_next = 8'h00;
      if (acc_addr[3:0] == 4'h0) begin
        rdata_next = gpio_q;
      end else if (acc_addr[3:0] == 4'h1) begin
        rdata_next = i_gpio;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gpio_q <= 8'h00;
    end else if (fire && acc_wr && !acc_rd && (acc_addr == 16'hFF00)) begin
      gpio_q <= acc_wdata;
    end
  end
`else
  logic unused_ok;

  assign in_window  = 1'b0;
  assign o_gpio     = 8'h00;
  assign rdata_next = mem[acc_idx];
  assign unused_ok  = ^{i_gpio, acc_addr};
`endif

  // The array has no reset, so its contents survive i_rst.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      o_rdata <= 8'h00;
      o_done  <= 1'b0;
      o_busy  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe) begin
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            rd_q    <= i_read;
            wr_q    <= i_write;
            cnt     <= WAIT_INIT;
            o_busy  <= 1'b1;
            if (i_read && i_write) begin
              o_err <= 1'b1;
            end
            if (WAIT_CYCLES == 0) begin
              state  <= ACCESS;
              o_done <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // A strobe that arrives while busy is dropped and flagged.
          if (strobe) begin
            o_err <= 1'b1;
          end
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= ACCESS;
            o_done <= 1'b1;
          end
        end
        ACCESS: begin
          if (strobe) begin
            o_err <= 1'b1;
          end
          o_done <= 1'b0;
          o_busy <= 1'b0;
          cnt    <= 4'd0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (rd_en) begin
        o_rdata <= rdata_next;
      end
    end
  end

endmodule
